// File: rtl/io_port_bridge_if.sv
// io_port_bridge_if: host byte streams and core I/O nibbles of io_port_bridge
//   IPORT   bridge->core  {c2h_ack, h2c_tog, h2c_data[1:0]}
//   OPORT   core->bridge  {h2c_ack, c2h_tog, c2h_data[1:0]}
//   S_VALID/S_READY/S_DATA  host->core byte stream
//   M_VALID/M_READY/M_DATA  core->host byte stream
interface io_port_bridge_if;
    logic [3:0] IPORT;
    logic [3:0] OPORT;
    logic       S_VALID;
    logic       S_READY;
    logic [7:0] S_DATA;
    logic       M_VALID;
    logic       M_READY;
    logic [7:0] M_DATA;
    modport master (
        input  IPORT, S_READY, M_VALID, M_DATA,
        output OPORT, S_VALID, S_DATA, M_READY
    );
    modport slave (
        output IPORT, S_READY, M_VALID, M_DATA,
        input  OPORT, S_VALID, S_DATA, M_READY
    );
endinterface

// File: rtl/io_port_bridge.sv
// io_port_bridge: moves host bytes to/from the accumulator core as 2-bit toggle-handshaked transfers
//   CLK   clock shared with the core
//   RSTN  synchronous active-low reset
//   bus   slave side of io_port_bridge_if (core nibbles IPORT/OPORT, host S_*/M_* byte streams)
//   DEPTH entries in each byte FIFO (power of 2, >= 2)
module io_port_bridge #(
    parameter int DEPTH = 4
) (
    input logic             CLK,
    input logic             RSTN,
    io_port_bridge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [7:0]  h2c_mem [DEPTH];
    logic [AW:0] h2c_wp, h2c_rp;
    logic [7:0]  h2c_head;
    logic        h2c_empty, h2c_full, h2c_push, h2c_pop, h2c_acked;
    logic [0:0]  state;
    logic [5:0]  sr;
    logic [1:0]  cnt, h2c_data;
    logic        h2c_tog;

    logic [7:0]  c2h_mem [DEPTH];
    logic [AW:0] c2h_wp, c2h_rp;
    logic        c2h_empty, c2h_full, c2h_push, c2h_pop;
    logic [5:0]  asm_r;
    logic [1:0]  ccnt;
    logic        c2h_ack, pending, capture;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign h2c_head  = h2c_mem[h2c_rp[AW-1:0]];
    assign h2c_empty = h2c_wp == h2c_rp;
    assign h2c_full  = h2c_wp == {~h2c_rp[AW], h2c_rp[AW-1:0]};
    assign h2c_push  = bus.S_VALID && !h2c_full;
    assign h2c_pop   = state == IDLE && !h2c_empty;
    assign h2c_acked = state == WAIT && bus.OPORT[3] == h2c_tog;

    assign c2h_empty = c2h_wp == c2h_rp;
    assign c2h_full  = c2h_wp == {~c2h_rp[AW], c2h_rp[AW-1:0]};
    assign c2h_pop   = !c2h_empty && bus.M_READY;
    assign pending   = bus.OPORT[2] != c2h_ack;
    // Only the byte-completing dibit needs FIFO space; it stalls unacked until a slot is free.
    assign capture   = pending && (ccnt != 2'd3 || !c2h_full);
    assign c2h_push  = capture && ccnt == 2'd3;

    assign bus.IPORT   = {c2h_ack, h2c_tog, h2c_data};
    assign bus.S_READY = !h2c_full;
    assign bus.M_VALID = !c2h_empty;
    assign bus.M_DATA  = c2h_mem[c2h_rp[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (h2c_push) h2c_mem[h2c_wp[AW-1:0]] <= bus.S_DATA;
        if (c2h_push) c2h_mem[c2h_wp[AW-1:0]] <= {asm_r, bus.OPORT[1:0]};
    end

    // h2c: the top dibit goes out on pop; sr keeps the remaining three, MSB first.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            h2c_wp   <= '0;
            h2c_rp   <= '0;
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            h2c_data <= '0;
            h2c_tog  <= 1'b0;
        end else begin
            if (h2c_push) h2c_wp <= h2c_wp + (AW+1)'(1);
            if (h2c_pop) begin
                h2c_rp   <= h2c_rp + (AW+1)'(1);
                sr       <= h2c_head[5:0];
                h2c_data <= h2c_head[7:6];
                h2c_tog  <= !h2c_tog;
                cnt      <= '0;
                state    <= WAIT;
            end else if (h2c_acked) begin
                if (cnt != 2'd3) begin
                    sr       <= {sr[3:0], 2'b00};
                    h2c_data <= sr[5:4];
                    h2c_tog  <= !h2c_tog;
                    cnt      <= cnt + 2'd1;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    // c2h: three dibits accumulate in asm_r; the fourth completes the byte straight into the FIFO.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            c2h_wp  <= '0;
            c2h_rp  <= '0;
            asm_r   <= '0;
            ccnt    <= '0;
            c2h_ack <= 1'b0;
        end else begin
            if (c2h_push) c2h_wp <= c2h_wp + (AW+1)'(1);
            if (c2h_pop) c2h_rp <= c2h_rp + (AW+1)'(1);
            if (capture) begin
                c2h_ack <= bus.OPORT[2];
                asm_r   <= {asm_r[3:0], bus.OPORT[1:0]};
                ccnt    <= ccnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: scoreboard bench for io_port_bridge with a background core model
module tb_io_port_bridge;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       o_ack = 1'b0;
    logic       o_tog = 1'b0;
    logic [1:0] o_dat = 2'b00;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         test_id = 0;
    bit         ack_en = 1'b1;
    bit         gap_chk = 1'b0;
    logic [1:0] h2c_q [$];
    logic [7:0] c2h_q [$];

    io_port_bridge_if bus ();
    assign bus.OPORT = {o_ack, o_tog, o_dat};

    io_port_bridge #(.DEPTH(4)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Core firmware model, h2c side: check each new dibit, ack it 3 cycles later.
    logic seen = 1'b0;
    logic pend = 1'b0;
    logic ack_last = 1'b0;
    int   tmr = 0;
    int   didx = 0;
    int   ack_cyc = 0;
    int   ack_tid = -1;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rstn) begin
            seen  = 1'b0;
            pend  = 1'b0;
            didx  = 0;
            o_ack = 1'b0;
        end else begin
            if (pend && ack_en) begin
                if (tmr > 1) tmr--;
                else begin
                    o_ack    = seen;
                    pend     = 1'b0;
                    ack_cyc  = cyc;
                    ack_last = didx == 0;
                    ack_tid  = test_id;
                end
            end
            if (bus.IPORT[2] != seen) begin
                seen = bus.IPORT[2];
                if (gap_chk && ack_tid == test_id) chk("h2c_gap", cyc - ack_cyc, ack_last ? 2 : 1);
                chk("h2c_expected", h2c_q.size() > 0, 1);
                if (h2c_q.size() > 0) chk("h2c_dibit", bus.IPORT[1:0], h2c_q.pop_front());
                didx = (didx + 1) % 4;
                pend = 1'b1;
                tmr  = 3;
            end
        end
    end

    // Host receive side: a byte leaves the c2h FIFO on the next edge.
    always @(negedge clk) begin
        if (rstn && bus.M_VALID && bus.M_READY) begin
            chk("c2h_expected", c2h_q.size() > 0, 1);
            if (c2h_q.size() > 0) chk("c2h_byte", bus.M_DATA, c2h_q.pop_front());
        end
    end

    task automatic push(input logic [7:0] b);
        int n = 0;
        bus.S_VALID = 1'b1;
        bus.S_DATA  = b;
        while (!bus.S_READY && n < 300) begin
            tick();
            n++;
        end
        chk("push_ready", bus.S_READY, 1);
        tick();
        bus.S_VALID = 1'b0;
        for (int i = 3; i >= 0; i--) h2c_q.push_back(b[2*i +: 2]);
    endtask

    task automatic send_dibit(input logic [1:0] d, input int lat);
        int n = 0;
        o_tog = !o_tog;
        o_dat = d;
        do begin
            tick();
            n++;
        end while (bus.IPORT[3] != o_tog && n < 50);
        chk("c2h_ack_lat", n, lat);
    endtask

    task automatic send_byte(input logic [7:0] b);
        c2h_q.push_back(b);
        for (int i = 3; i >= 0; i--) send_dibit(b[2*i +: 2], 1);
    endtask

    task automatic drain_h2c();
        int n = 0;
        while ((h2c_q.size() > 0 || pend) && n < 2000) begin
            tick();
            n++;
        end
        chk("h2c_drain", h2c_q.size(), 0);
        chk("h2c_acks_done", pend, 0);
        tick(4);
    endtask

    task automatic drain_c2h();
        int n = 0;
        bus.M_READY = 1'b1;
        while (c2h_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("c2h_drain", c2h_q.size(), 0);
        tick();
        chk("c2h_empty", bus.M_VALID, 0);
        bus.M_READY = 1'b0;
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        o_tog = 1'b0;
        o_dat = 2'b00;
        h2c_q.delete();
        c2h_q.delete();
        tick();
        chk("rst_iport", bus.IPORT, 4'b0000);
        chk("rst_s_ready", bus.S_READY, 1);
        chk("rst_m_valid", bus.M_VALID, 0);
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        bus.S_VALID = 1'b0;
        bus.S_DATA  = 8'h00;
        bus.M_READY = 1'b0;

        test_id = 1;
        do_reset();
        tick(3);
        chk("idle_iport", bus.IPORT, 4'b0000);
        chk("idle_s_ready", bus.S_READY, 1);
        chk("idle_m_valid", bus.M_VALID, 0);

        test_id = 2;
        gap_chk = 1'b1;
        push(8'hB4);
        push(8'h5A);
        chk("h2c_first", bus.IPORT, 4'b0110);
        drain_h2c();

        test_id = 3;
        ack_en  = 1'b0;
        push(8'h1E);
        push(8'hC3);
        push(8'h5A);
        push(8'h96);
        chk("bp_ready_3q", bus.S_READY, 1);
        push(8'h0F);
        chk("bp_full", bus.S_READY, 0);
        tick(5);
        chk("bp_still_full", bus.S_READY, 0);
        ack_en = 1'b1;
        drain_h2c();
        gap_chk = 1'b0;

        test_id = 4;
        c2h_q.push_back(8'h6C);
        send_dibit(2'd1, 1);
        send_dibit(2'd2, 1);
        send_dibit(2'd3, 1);
        chk("c2h_partial", bus.M_VALID, 0);
        send_dibit(2'd0, 1);
        chk("c2h_mvalid", bus.M_VALID, 1);
        chk("c2h_mdata", bus.M_DATA, 8'h6C);
        drain_c2h();

        test_id = 5;
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hF0);
        send_byte(8'h0F);
        c2h_q.push_back(8'h99);
        send_dibit(2'd2, 1);
        send_dibit(2'd1, 1);
        send_dibit(2'd2, 1);
        o_tog = !o_tog;
        o_dat = 2'd1;
        tick(4);
        chk("c2h_stall", bus.IPORT[3], !o_tog);
        chk("c2h_head", bus.M_DATA, 8'hA5);
        bus.M_READY = 1'b1;
        tick();
        bus.M_READY = 1'b0;
        chk("c2h_no_ack_at_pop", bus.IPORT[3], !o_tog);
        tick();
        chk("c2h_ack_after_pop", bus.IPORT[3], o_tog);
        drain_c2h();

        test_id = 6;
        fork
            push(8'hFF);
            begin
                send_dibit(2'd2, 1);
                send_dibit(2'd0, 1);
            end
        join
        tick(2);
        do_reset();
        tick();
        chk("post_rst_iport", bus.IPORT, 4'b0000);
        chk("post_rst_m_valid", bus.M_VALID, 0);

        test_id = 7;
        fork
            push(8'h3C);
            send_byte(8'h81);
        join
        drain_h2c();
        drain_c2h();

        chk("h2c_left", h2c_q.size(), 0);
        chk("c2h_left", c2h_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
